cursor_tab_control: RTL and testbench
=====================================

# cursor_tab_control

Parametrised cursor engine for the terminal parser. It consumes decoded cursor commands and printable or control characters, and maintains the cursor row/column within a configurable screen. It also keeps a programmable tab-stop register and a saved-cursor slot. Scroll requests go out over a valid/ready handshake to the text-buffer scroller, and a blink-gated visibility bit goes to the renderer.

## Interface
- `LINES`, default 30: screen rows.
- `COLUMNS`, default 80: screen columns, at most 255.
- `TAB_WIDTH`, default 8: reset spacing of tab stops.
- `BLINK_DIV`, default 50_000_000: clk cycles per blink phase.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_op`  in  4: opcode.
  - 0 NOP, 1 CUP, 2 CUF, 3 CUB, 4 CUD, 5 CUU, 6 IND, 7 RI
  - 8 NEL, 9 CHAR, 10 HTS, 11 TBC, 12 CHT, 13 CBT, 14 SAVE, 15 RESTORE
- `cmd_p1`, `cmd_p2`  in  8 each: numeric parameters; 0 means default.
- `cmd_char`  in  8: character, used when the opcode is CHAR.
- `origin_mode`, `auto_wrap`, `line_feed`, `cur_en`, `blink_en`  in  1 each: terminal mode bits.
- `scroll_top`, `scroll_bottom`  in  8 each: scroll region bounds, absolute rows, top ≤ bottom < LINES.
- `cur_row`, `cur_col`  out  8 each: absolute cursor position.
- `cur_visible`  out  1: `cur_en & (blink_en ? blink_phase : 1)`.
- `scroll_valid`  out  1: scroll request pending.
- `scroll_ready`  in  1: scroller accepts the request.
- `scroll_dir`  out  1: 0 = up (content moves up), 1 = down.
- `scroll_lo`, `scroll_hi`  out  8 each: region latched at request time.

## Operation
**Derived values**
- `org = origin_mode ? scroll_top : 0`.
- `rmax = origin_mode ? scroll_bottom : LINES-1`.
- `n = (p1==0) ? 1 : p1`.

**Cursor opcodes**
- CUP:
  - row = `min(org + max(p1,1) - 1, rmax)`.
  - col = `min(max(p2,1) - 1, COLUMNS-1)`.
- CUF: col += n, saturating at COLUMNS-1.
- CUB: col -= n, saturating at 0.
- CUD: row += n, saturating at `(row ≤ scroll_bottom ? scroll_bottom : LINES-1)`.
- CUU: row -= n, saturating at `(row ≥ scroll_top ? scroll_top : 0)`.
- IND:
  - If row == scroll_bottom: issue a scroll-up; row is unchanged.
  - Otherwise row+1, saturating at LINES-1.
- NEL: same as IND, and col = 0.
- RI:
  - If row == scroll_top: issue a scroll-down.
  - Otherwise row-1, saturating at 0.

**CHAR**
- 0x0A/0x0B/0x0C: IND; col = 0 if `line_feed`.
- 0x0D: col = 0.
- 0x08: col-1, saturating at 0.
- 0x09: same as CHT with n = 1.
- Any other character:
  - If col < COLUMNS-1: col+1.
  - Else if `auto_wrap`: col = 0, then IND.
  - Else: col stays.

**Tab stops**
- `tabs[COLUMNS]` holds the stops. Reset sets bit c where `c % TAB_WIDTH == 0` and c ≠ 0.
- HTS sets `tabs[col]`.
- TBC:
  - p1 = 0 clears `tabs[col]`.
  - p1 = 3 clears all stops.
  - Any other value is a no-op.
- CHT n:
  - Advance col to the next set stop, n times.
  - With no further stop, col = COLUMNS-1 and the search ends.
- CBT n:
  - Same as CHT, moving backward.
  - With no earlier stop, col = 0.

**Saved cursor**
- SAVE copies row/col into the save slot.
- RESTORE loads row/col from the slot.
- The slot resets to (0,0).

**FSM states**
- IDLE: `cmd_ready` = 1.
  - Accept occurs when `cmd_valid & cmd_ready`.
  - CHT, CBT and HT go to TAB.
  - An accept that requests a scroll goes to SCROLL.
  - Everything else stays in IDLE.
- TAB: steps col by one column per cycle.
  - Decrements the remaining count on each set stop it lands on.
  - Returns to IDLE when the count reaches 0 or col hits the edge.
- SCROLL:
  - `scroll_valid` = 1; `scroll_dir`/`lo`/`hi` are held stable.
  - Returns to IDLE on `scroll_valid & scroll_ready`.
- `cmd_ready` = 0 in TAB and SCROLL.

**Reset**
- `rst_n` low forces, asynchronously, mid-operation included:
  - state = IDLE, row = col = 0;
  - `scroll_valid` = 0, scroll fields = 0;
  - tabs and save slot to their defaults;
  - blink counter = 0, blink phase = 1.

## Timing
- Simple opcodes: row/col updated on the clock edge after the accept (one-cycle latency).
- Scroll:
  - The cursor update and `scroll_valid` rise together on the edge after the accept.
  - The earliest `scroll_valid` drop is the edge after a cycle with `scroll_ready` = 1.
  - `scroll_ready` high while `scroll_valid` = 0 has no effect.
- Tab search:
  - k column steps take k cycles after the accept.
  - `cmd_ready` returns on the edge where the final col is written.
- Mode and region inputs are sampled at accept. The scroll region is latched at entry to SCROLL.
- Blink: the counter wraps at BLINK_DIV-1 and toggles the phase on the wrap. It is unaffected by commands.

## Test plan
- Reset defaults:
  - Drive `rst_n` = 0 mid-TAB search → row = col = 0, `scroll_valid` = 0, `cmd_ready` = 1, `tabs[8]` = 1.
  - CHT n = 1 from col 0 → col 8 after 8 cycles.
- CUP with origin_mode = 1, region 5..10:
  - p1 = 20, p2 = 0 → row 10, col 0.
  - Then CUU n = 9 → row 5.
- Auto-wrap scroll: row = scroll_bottom = 29, col 79, auto_wrap = 1, CHAR 'A' → col 0, row 29.
  - `scroll_valid` = 1 with dir 0, lo 0, hi 29, held for 3 cycles with `scroll_ready` = 0.
  - `cmd_ready` = 0 throughout; clears one edge after `scroll_ready` = 1.
- Tab register operations:
  - TBC p1 = 3, then HTS at col 5, then CR, then HT → col 5.
  - Another HT → col 79.
  - CBT n = 2 from 79 → col 0.
- Reverse index at region top: RI at row = scroll_top = 3 → row 3, scroll dir 1, lo 3.
  - RI at row 2 with top 3 → row 1, no scroll.
- Save/restore and blink:
  - SAVE at (7,12), CUP (1,1), RESTORE → (7,12).
  - With BLINK_DIV = 4, blink_en = 1: `cur_visible` toggles every 4 cycles.
  - With cur_en = 0: `cur_visible` stays 0.

Source files
------------

// File: rtl/cursor_tab_control.sv
// Cursor engine: tracks row/col, tab stops and the saved cursor, and issues scroll requests.
// Latency: simple opcodes take 1 cycle; tab searches take 1 cycle per column stepped; scrolls last until scroll_ready.
// Backpressure: cmd_ready is low while a tab search or scroll request is in flight; scroll_valid is held until scroll_ready.
module cursor_tab_control #(
  parameter int LINES     = 30,
  parameter int COLUMNS   = 80,
  parameter int TAB_WIDTH = 8,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_p1,
  input  logic [7:0] cmd_p2,
  input  logic [7:0] cmd_char,
  input  logic       origin_mode,
  input  logic       auto_wrap,
  input  logic       line_feed,
  input  logic       cur_en,
  input  logic       blink_en,
  input  logic [7:0] scroll_top,
  input  logic [7:0] scroll_bottom,
  output logic [7:0] cur_row,
  output logic [7:0] cur_col,
  output logic       cur_visible,
  output logic       scroll_valid,
  input  logic       scroll_ready,
  output logic       scroll_dir,
  output logic [7:0] scroll_lo,
  output logic [7:0] scroll_hi
);

  localparam logic [3:0] OP_CUP = 4'd1,  OP_CUF = 4'd2,  OP_CUB = 4'd3,  OP_CUD = 4'd4;
  localparam logic [3:0] OP_CUU = 4'd5,  OP_IND = 4'd6,  OP_RI  = 4'd7,  OP_NEL = 4'd8;
  localparam logic [3:0] OP_CHR = 4'd9,  OP_HTS = 4'd10, OP_TBC = 4'd11, OP_CHT = 4'd12;
  localparam logic [3:0] OP_CBT = 4'd13, OP_SAV = 4'd14, OP_RST = 4'd15;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_TAB, S_SCROLL} state_t;

  // Tab map is 256 wide so an 8-bit column indexes it directly; bits at or above COLUMNS stay 0.
  function automatic logic [255:0] tab_default();
    logic [255:0] t;
    t = '0;
    for (int c = 1; c < COLUMNS; c++) begin
      if (c % TAB_WIDTH == 0) t[8'(c)] = 1'b1;
    end
    return t;
  endfunction
  localparam logic [255:0] TAB_RST = tab_default();

  state_t        state_q, state_d;
  logic [7:0]    row_q, row_d, col_q, col_d;
  logic [255:0]  tabs_q, tabs_d;
  logic [7:0]    save_row_q, save_row_d, save_col_q, save_col_d;
  logic [7:0]    tab_cnt_q, tab_cnt_d;
  logic          tab_fwd_q, tab_fwd_d;
  logic          scroll_valid_q, scroll_valid_d, scroll_dir_q, scroll_dir_d;
  logic [7:0]    scroll_lo_q, scroll_lo_d, scroll_hi_q, scroll_hi_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  // Next-state logic: command decode in IDLE, one column per cycle in TAB, handshake wait in SCROLL.
  always_comb begin : next_state
    int row, col, p1, p2, top, bot, org, rmax, n, lim, nrow, ncol;
    logic ind, ri, tab, fwd, scr, dir;
    logic [7:0] tn, step, cnt_left;
    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    tabs_d         = tabs_q;
    save_row_d     = save_row_q;
    save_col_d     = save_col_q;
    tab_cnt_d      = tab_cnt_q;
    tab_fwd_d      = tab_fwd_q;
    scroll_valid_d = scroll_valid_q;
    scroll_dir_d   = scroll_dir_q;
    scroll_lo_d    = scroll_lo_q;
    scroll_hi_d    = scroll_hi_q;
    row  = int'(row_q);
    col  = int'(col_q);
    p1   = int'(cmd_p1);
    p2   = int'(cmd_p2);
    top  = int'(scroll_top);
    bot  = int'(scroll_bottom);
    org  = origin_mode ? top : 0;
    rmax = origin_mode ? bot : LINES - 1;
    n    = (p1 == 0) ? 1 : p1;
    lim  = 0;
    nrow = 0;
    ncol = 0;
    ind  = 1'b0;
    ri   = 1'b0;
    tab  = 1'b0;
    fwd  = 1'b1;
    scr  = 1'b0;
    dir  = 1'b0;
    tn   = (cmd_p1 == 8'd0) ? 8'd1 : cmd_p1;
    step = tab_fwd_q ? col_q + 8'd1 : col_q - 8'd1;
    cnt_left = tab_cnt_q - {7'd0, tabs_q[step]};

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CUP: begin
              nrow  = org + ((p1 == 0) ? 1 : p1) - 1;
              row_d = 8'((nrow > rmax) ? rmax : nrow);
              ncol  = ((p2 == 0) ? 1 : p2) - 1;
              col_d = 8'((ncol > COLUMNS - 1) ? COLUMNS - 1 : ncol);
            end
            OP_CUF: begin
              ncol  = col + n;
              col_d = 8'((ncol > COLUMNS - 1) ? COLUMNS - 1 : ncol);
            end
            OP_CUB: begin
              ncol  = col - n;
              col_d = 8'((ncol < 0) ? 0 : ncol);
            end
            OP_CUD: begin
              lim   = (row <= bot) ? bot : LINES - 1;
              nrow  = row + n;
              row_d = 8'((nrow > lim) ? lim : nrow);
            end
            OP_CUU: begin
              lim   = (row >= top) ? top : 0;
              nrow  = row - n;
              row_d = 8'((nrow < lim) ? lim : nrow);
            end
            OP_IND: ind = 1'b1;
            OP_RI:  ri  = 1'b1;
            OP_NEL: begin
              ind   = 1'b1;
              col_d = 8'd0;
            end
            OP_CHR: begin
              case (cmd_char)
                8'h0A, 8'h0B, 8'h0C: begin
                  ind = 1'b1;
                  if (line_feed) col_d = 8'd0;
                end
                8'h0D: col_d = 8'd0;
                8'h08: col_d = (col_q == 8'd0) ? 8'd0 : col_q - 8'd1;
                8'h09: begin
                  tab = 1'b1;
                  tn  = 8'd1;
                end
                default: begin
                  if (col < COLUMNS - 1) begin
                    col_d = col_q + 8'd1;
                  end else if (auto_wrap) begin
                    col_d = 8'd0;
                    ind   = 1'b1;
                  end
                end
              endcase
            end
            OP_HTS: tabs_d[col_q] = 1'b1;
            OP_TBC: begin
              if (cmd_p1 == 8'd0)      tabs_d[col_q] = 1'b0;
              else if (cmd_p1 == 8'd3) tabs_d = '0;
            end
            OP_CHT: tab = 1'b1;
            OP_CBT: begin
              tab = 1'b1;
              fwd = 1'b0;
            end
            OP_SAV: begin
              save_row_d = row_q;
              save_col_d = col_q;
            end
            OP_RST: begin
              row_d = save_row_q;
              col_d = save_col_q;
            end
            default: ;
          endcase
          // Line moves at the region edge become scroll requests instead of cursor moves.
          if (ind) begin
            if (row_q == scroll_bottom) scr = 1'b1;
            else row_d = 8'((row + 1 > LINES - 1) ? LINES - 1 : row + 1);
          end
          if (ri) begin
            if (row_q == scroll_top) begin
              scr = 1'b1;
              dir = 1'b1;
            end else begin
              row_d = (row_q == 8'd0) ? 8'd0 : row_q - 8'd1;
            end
          end
          if (scr) begin
            state_d        = S_SCROLL;
            scroll_valid_d = 1'b1;
            scroll_dir_d   = dir;
            scroll_lo_d    = scroll_top;
            scroll_hi_d    = scroll_bottom;
          end
          // A search that starts on the edge it heads for has nothing to do.
          if (tab && !(fwd ? (col_q == 8'(COLUMNS - 1)) : (col_q == 8'd0))) begin
            state_d   = S_TAB;
            tab_cnt_d = tn;
            tab_fwd_d = fwd;
          end
        end
      end
      S_TAB: begin
        col_d     = step;
        tab_cnt_d = cnt_left;
        if (cnt_left == 8'd0 || (tab_fwd_q ? (step == 8'(COLUMNS - 1)) : (step == 8'd0)))
          state_d = S_IDLE;
      end
      S_SCROLL: begin
        if (scroll_ready) begin
          scroll_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    blink_cnt_d = (blink_cnt_q == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + BW'(1);
    blink_ph_d  = (blink_cnt_q == BW'(BLINK_DIV - 1)) ? ~blink_ph_q : blink_ph_q;
  end

  // State registers with asynchronous return to power-on defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      row_q          <= '0;
      col_q          <= '0;
      tabs_q         <= TAB_RST;
      save_row_q     <= '0;
      save_col_q     <= '0;
      tab_cnt_q      <= '0;
      tab_fwd_q      <= 1'b1;
      scroll_valid_q <= 1'b0;
      scroll_dir_q   <= 1'b0;
      scroll_lo_q    <= '0;
      scroll_hi_q    <= '0;
      blink_cnt_q    <= '0;
      blink_ph_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      col_q          <= col_d;
      tabs_q         <= tabs_d;
      save_row_q     <= save_row_d;
      save_col_q     <= save_col_d;
      tab_cnt_q      <= tab_cnt_d;
      tab_fwd_q      <= tab_fwd_d;
      scroll_valid_q <= scroll_valid_d;
      scroll_dir_q   <= scroll_dir_d;
      scroll_lo_q    <= scroll_lo_d;
      scroll_hi_q    <= scroll_hi_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_ph_q     <= blink_ph_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign cur_row      = row_q;
  assign cur_col      = col_q;
  assign cur_visible  = cur_en & (blink_en ? blink_ph_q : 1'b1);
  assign scroll_valid = scroll_valid_q;
  assign scroll_dir   = scroll_dir_q;
  assign scroll_lo    = scroll_lo_q;
  assign scroll_hi    = scroll_hi_q;

endmodule

// File: tb/tb_cursor_tab_control.sv
// Bench for cursor_tab_control: directed scenarios with literal expectations, then random commands.
// A reference model tracks the cursor, tab map, save slot and expected handshake timing.
// One negedge compare process checks the DUT against the model every cycle.
module tb_cursor_tab_control;
  localparam int L  = 30;
  localparam int C  = 80;
  localparam int BD = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_p1 = '0, cmd_p2 = '0, cmd_char = '0;
  logic       origin_mode = 1'b0, auto_wrap = 1'b0, line_feed = 1'b0, cur_en = 1'b1, blink_en = 1'b0;
  logic [7:0] scroll_top = 8'd0, scroll_bottom = 8'd29;
  logic [7:0] cur_row, cur_col, scroll_lo, scroll_hi;
  logic       cur_visible, scroll_valid, scroll_ready = 1'b0, scroll_dir;

  always #5 clk = ~clk;

  cursor_tab_control #(.LINES(L), .COLUMNS(C), .TAB_WIDTH(8), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_p1(cmd_p1), .cmd_p2(cmd_p2), .cmd_char(cmd_char), .origin_mode(origin_mode),
    .auto_wrap(auto_wrap), .line_feed(line_feed), .cur_en(cur_en), .blink_en(blink_en),
    .scroll_top(scroll_top), .scroll_bottom(scroll_bottom), .cur_row(cur_row), .cur_col(cur_col),
    .cur_visible(cur_visible), .scroll_valid(scroll_valid), .scroll_ready(scroll_ready),
    .scroll_dir(scroll_dir), .scroll_lo(scroll_lo), .scroll_hi(scroll_hi));

  int nchk = 0, nerr = 0;
  int m_row, m_col, m_sr, m_sc;
  bit m_tabs[256];
  bit exp_ready, exp_sv, exp_dir, col_ok, chk_en = 1'b0;
  int exp_lo, exp_hi, busy_cnt, tcnt;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int mn(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int mx(input int a, input int b); return (a > b) ? a : b; endfunction

  // Clock edges since reset release; the blink phase follows from this alone.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= 0;
    else        tcnt <= tcnt + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("row", int'(cur_row), m_row);
      if (col_ok) chk("col", int'(cur_col), m_col);
      chk("cmd_ready", int'(cmd_ready), int'(exp_ready));
      chk("scroll_valid", int'(scroll_valid), int'(exp_sv));
      if (exp_sv) begin
        chk("scroll_dir", int'(scroll_dir), int'(exp_dir));
        chk("scroll_lo", int'(scroll_lo), exp_lo);
        chk("scroll_hi", int'(scroll_hi), exp_hi);
      end
      chk("cur_visible", int'(cur_visible), int'(cur_en && (!blink_en || ((tcnt / BD) % 2 == 0))));
      if (!cmd_ready) busy_cnt++;
    end
  end

  task automatic model_reset();
    m_row = 0; m_col = 0; m_sr = 0; m_sc = 0;
    for (int i = 0; i < 256; i++) m_tabs[i] = (i < C) && (i != 0) && (i % 8 == 0);
    exp_ready = 1'b1; exp_sv = 1'b0; exp_dir = 1'b0; exp_lo = 0; exp_hi = 0; col_ok = 1'b1;
  endtask

  // Outcome of one accepted command: new cursor/tabs/slot, whether it scrolls, and tab steps taken.
  task automatic model_cmd(input int op, input int p1, input int p2, input int ch,
                           output bit scr, output bit sdir, output int k);
    int top, bot, org, rmax, n, r0, c0, tn, c;
    bit ind, ri, tab, fwd, found;
    top = int'(scroll_top); bot = int'(scroll_bottom);
    org = origin_mode ? top : 0; rmax = origin_mode ? bot : L - 1;
    n = (p1 == 0) ? 1 : p1; tn = n;
    r0 = m_row; c0 = m_col;
    scr = 0; sdir = 0; k = 0; ind = 0; ri = 0; tab = 0; fwd = 1;
    case (op)
      1: begin m_row = mn(org + mx(p1, 1) - 1, rmax); m_col = mn(mx(p2, 1) - 1, C - 1); end
      2: m_col = mn(c0 + n, C - 1);
      3: m_col = mx(c0 - n, 0);
      4: m_row = mn(r0 + n, (r0 <= bot) ? bot : L - 1);
      5: m_row = mx(r0 - n, (r0 >= top) ? top : 0);
      6: ind = 1;
      7: ri = 1;
      8: begin ind = 1; m_col = 0; end
      9: begin
        if (ch == 10 || ch == 11 || ch == 12) begin ind = 1; if (line_feed) m_col = 0; end
        else if (ch == 13) m_col = 0;
        else if (ch == 8) m_col = mx(c0 - 1, 0);
        else if (ch == 9) begin tab = 1; tn = 1; end
        else if (c0 < C - 1) m_col = c0 + 1;
        else if (auto_wrap) begin m_col = 0; ind = 1; end
      end
      10: m_tabs[c0] = 1;
      11: if (p1 == 0) m_tabs[c0] = 0;
          else if (p1 == 3) for (int i = 0; i < 256; i++) m_tabs[i] = 0;
      12: tab = 1;
      13: begin tab = 1; fwd = 0; end
      14: begin m_sr = r0; m_sc = c0; end
      15: begin m_row = m_sr; m_col = m_sc; end
      default: ;
    endcase
    if (ind) begin
      if (r0 == bot) scr = 1; else m_row = mn(r0 + 1, L - 1);
    end
    if (ri) begin
      if (r0 == top) begin scr = 1; sdir = 1; end else m_row = mx(r0 - 1, 0);
    end
    if (tab) begin
      c = c0;
      for (int i = 0; i < tn; i++) begin
        found = 0;
        if (fwd) begin
          for (int x = c + 1; x < C; x++) if (m_tabs[x]) begin c = x; found = 1; break; end
          if (!found) c = C - 1;
        end else begin
          for (int x = c - 1; x >= 0; x--) if (m_tabs[x]) begin c = x; found = 1; break; end
          if (!found) c = 0;
        end
        if (!found) break;
      end
      k = fwd ? c - c0 : c0 - c;
      m_col = c;
    end
  endtask

  // Present one command for one cycle, then follow its expected timing; hold < 0 picks a random scroll wait.
  task automatic issue(input int op, input int p1, input int p2, input int ch, input int hold);
    bit scr, sdir;
    int k, wt;
    cmd_op = 4'(op); cmd_p1 = 8'(p1); cmd_p2 = 8'(p2); cmd_char = 8'(ch);
    cmd_valid = 1'b1; scroll_ready = 1'($urandom % 2);
    @(posedge clk); #1;
    cmd_valid = 1'b0; scroll_ready = 1'b0;
    model_cmd(op, p1, p2, ch, scr, sdir, k);
    if (scr) begin
      exp_sv = 1'b1; exp_dir = sdir; exp_lo = int'(scroll_top); exp_hi = int'(scroll_bottom);
      exp_ready = 1'b0;
      wt = (hold < 0) ? $urandom_range(0, 3) : hold;
      repeat (wt) begin @(posedge clk); #1; end
      scroll_ready = 1'b1;
      @(posedge clk); #1;
      scroll_ready = 1'b0; exp_sv = 1'b0; exp_ready = 1'b1;
    end else if (k > 0) begin
      exp_ready = 1'b0; col_ok = 1'b0;
      repeat (k) begin @(posedge clk); #1; end
      col_ok = 1'b1; exp_ready = 1'b1;
    end
  endtask

  task automatic set_modes(input bit om, input bit aw, input bit lf, input int top, input int bot);
    origin_mode = om; auto_wrap = aw; line_feed = lf;
    scroll_top = 8'(top); scroll_bottom = 8'(bot);
  endtask

  initial begin
    int v[16];
    int ok, ones, op, p1, p2, ch, sel, top;
    set_modes(0, 0, 0, 0, L - 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_row", int'(cur_row), 0);
    chk("rst_col", int'(cur_col), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_sv", int'(scroll_valid), 0);
    chk("rst_fields", int'({scroll_dir, scroll_lo, scroll_hi}), 0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a tab search.
    chk_en = 1'b0;
    cmd_op = 4'd12; cmd_p1 = 8'd2; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midtab_ready", int'(cmd_ready), 0);
    chk("midtab_col", int'(cur_col), 3);
    rst_n = 1'b0;
    #2;
    chk("arst_row", int'(cur_row), 0);
    chk("arst_col", int'(cur_col), 0);
    chk("arst_ready", int'(cmd_ready), 1);
    chk("arst_sv", int'(scroll_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    busy_cnt = 0;
    issue(12, 1, 0, 0, 0);
    chk("cht_col", int'(cur_col), 8);
    chk("cht_cycles", busy_cnt, 8);

    set_modes(1, 0, 0, 5, 10);
    issue(1, 20, 0, 0, 0);
    chk("cup_org_row", int'(cur_row), 10);
    chk("cup_org_col", int'(cur_col), 0);
    issue(5, 9, 0, 0, 0);
    chk("cuu_row", int'(cur_row), 5);

    set_modes(0, 1, 0, 0, 29);
    issue(1, 30, 80, 0, 0);
    chk("pos_row", int'(cur_row), 29);
    chk("pos_col", int'(cur_col), 79);
    busy_cnt = 0;
    fork
      issue(9, 0, 0, 8'h41, 3);
      begin
        @(posedge clk); #3;
        chk("wrap_sv", int'(scroll_valid), 1);
        chk("wrap_dir", int'(scroll_dir), 0);
        chk("wrap_lo", int'(scroll_lo), 0);
        chk("wrap_hi", int'(scroll_hi), 29);
        chk("wrap_row", int'(cur_row), 29);
        chk("wrap_col", int'(cur_col), 0);
        chk("wrap_ready", int'(cmd_ready), 0);
      end
    join
    chk("wrap_busy", busy_cnt, 4);
    chk("wrap_sv_drop", int'(scroll_valid), 0);

    set_modes(0, 0, 0, 0, 29);
    issue(11, 3, 0, 0, 0);
    issue(1, 1, 6, 0, 0);
    issue(10, 0, 0, 0, 0);
    issue(9, 0, 0, 8'h0D, 0);
    chk("cr_col", int'(cur_col), 0);
    issue(9, 0, 0, 8'h09, 0);
    chk("ht1_col", int'(cur_col), 5);
    issue(9, 0, 0, 8'h09, 0);
    chk("ht2_col", int'(cur_col), 79);
    issue(13, 2, 0, 0, 0);
    chk("cbt_col", int'(cur_col), 0);

    set_modes(0, 0, 0, 3, 20);
    issue(1, 4, 1, 0, 0);
    fork
      issue(7, 0, 0, 0, 1);
      begin
        @(posedge clk); #3;
        chk("ri_sv", int'(scroll_valid), 1);
        chk("ri_dir", int'(scroll_dir), 1);
        chk("ri_lo", int'(scroll_lo), 3);
        chk("ri_row", int'(cur_row), 3);
      end
    join
    issue(1, 3, 1, 0, 0);
    busy_cnt = 0;
    issue(7, 0, 0, 0, 0);
    chk("ri_move_row", int'(cur_row), 1);
    chk("ri_no_scroll", busy_cnt, 0);

    set_modes(0, 0, 0, 0, 29);
    issue(1, 8, 13, 0, 0);
    issue(14, 0, 0, 0, 0);
    issue(1, 1, 1, 0, 0);
    issue(15, 0, 0, 0, 0);
    chk("restore_row", int'(cur_row), 7);
    chk("restore_col", int'(cur_col), 12);

    cur_en = 1'b1; blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin @(negedge clk); v[i] = int'(cur_visible); end
    ok = 1;
    for (int i = 0; i < 8; i++) if (v[i] == v[i + 4] || v[i] != v[i + 8]) ok = 0;
    chk("blink_period", ok, 1);
    @(posedge clk); #1 cur_en = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); ones += int'(cur_visible); end
    chk("vis_off", ones, 0);
    @(posedge clk); #1;

    for (int it = 0; it < 400; it++) begin
      if ($urandom % 8 == 0) begin
        cur_en = 1'($urandom % 4 != 0); blink_en = 1'($urandom % 2);
      end
      if ($urandom % 2 == 0) set_modes(1'($urandom % 4 == 0), 1'($urandom % 2), 1'($urandom % 2), 0, L - 1);
      else begin
        top = $urandom_range(0, L - 1);
        set_modes(1'($urandom % 4 == 0), 1'($urandom % 2), 1'($urandom % 2), top, $urandom_range(top, L - 1));
      end
      op = ($urandom % 3 == 0) ? 9 : $urandom_range(0, 15);
      p1 = ($urandom % 4 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      p2 = ($urandom % 4 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 90);
      if (op == 11) begin
        sel = $urandom % 3;
        p1 = (sel == 0) ? 0 : (sel == 1) ? 3 : $urandom_range(1, 9);
      end
      sel = $urandom % 10;
      case (sel)
        0: ch = 10; 1: ch = 11; 2: ch = 12; 3: ch = 13; 4: ch = 8; 5: ch = 9;
        default: ch = $urandom_range(32, 126);
      endcase
      issue(op, p1, p2, ch, -1);
      repeat ($urandom % 3) begin
        scroll_ready = 1'($urandom % 2);
        @(posedge clk); #1;
      end
      scroll_ready = 1'b0;
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
